// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the multi-pulse sequencer: FSM states, the
// double-buffered configuration bank and slice accessors for flattened buses.
package pulse_seq_pkg;

  localparam int SEQ_NUM_PULSES  = 3;
  localparam int SEQ_CNT_W       = 32;
  localparam int SEQ_ATT_W       = 7;
  localparam int SEQ_CPMG_W      = 8;
  localparam int SEQ_BLOCK_SCALE = 10;

  localparam logic [SEQ_ATT_W-1:0] ATT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  // One complete timing configuration; the pending and active banks share it.
  typedef struct packed {
    logic [SEQ_CNT_W-1:0]                period;
    logic [SEQ_CNT_W-1:0]                sync_width;
    logic [SEQ_NUM_PULSES-1:0]           p_en;
    logic [SEQ_NUM_PULSES*SEQ_CNT_W-1:0] p_start;
    logic [SEQ_NUM_PULSES*SEQ_CNT_W-1:0] p_width;
    logic [SEQ_NUM_PULSES*SEQ_ATT_W-1:0] p_att;
    logic [SEQ_ATT_W-1:0]                base_att;
    logic [SEQ_CPMG_W-1:0]               cpmg_count;
    logic [SEQ_CNT_W-1:0]                cpmg_delay;
    logic [SEQ_CNT_W-1:0]                cpmg_width;
    logic                                block_en;
    logic [7:0]                          block_hold;
    logic [SEQ_CNT_W-1:0]                rx_end;
  } cfg_bank_t;

  function automatic logic [SEQ_CNT_W-1:0] cnt_slice(
    input logic [SEQ_NUM_PULSES*SEQ_CNT_W-1:0] bus,
    input int                                  idx
  );
    return bus[idx*SEQ_CNT_W +: SEQ_CNT_W];
  endfunction

  function automatic logic [SEQ_ATT_W-1:0] att_slice(
    input logic [SEQ_NUM_PULSES*SEQ_ATT_W-1:0] bus,
    input int                                  idx
  );
    return bus[idx*SEQ_ATT_W +: SEQ_ATT_W];
  endfunction

endpackage

// File: rtl/pulse_sequencer_window.sv
// Registered window compare for one pulse: active one clock after t lands in
// [start, start+width), with the end computed one bit wider so it never wraps.
module pulse_window
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W,
  parameter int ATT_W = SEQ_ATT_W
) (
  input  logic             clk_pll,
  input  logic             reset,
  input  logic             run,
  input  logic             en,
  input  logic [CNT_W-1:0] t,
  input  logic [CNT_W-1:0] start,
  input  logic [CNT_W-1:0] width,
  input  logic [ATT_W-1:0] att_in,
  output logic             active,
  output logic [ATT_W-1:0] att
);

  logic [CNT_W:0] stop;
  logic           hit;

  assign stop = {1'b0, start} + {1'b0, width};
  assign hit  = run && en && (t >= start) && ({1'b0, t} < stop);

  // The attenuation word is captured alongside the gate so both describe the same t.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      active <= 1'b0;
      att    <= '1;
    end else begin
      active <= hit;
      att    <= att_in;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Multi-pulse sequencer: per-period scope sync, RF gate, attenuator word and
// blocking gate, with optional CPMG echo train and double-buffered timing.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int NUM_PULSES  = SEQ_NUM_PULSES,
  parameter int CNT_W       = SEQ_CNT_W,
  parameter int ATT_W       = SEQ_ATT_W,
  parameter int CPMG_W      = SEQ_CPMG_W,
  parameter int BLOCK_SCALE = SEQ_BLOCK_SCALE
) (
  input  logic                        clk_pll,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        trig_mode,
  input  logic                        trig,
  input  logic                        load,
  input  logic [CNT_W-1:0]            period,
  input  logic [CNT_W-1:0]            sync_width,
  input  logic [NUM_PULSES-1:0]       p_en,
  input  logic [NUM_PULSES*CNT_W-1:0] p_start,
  input  logic [NUM_PULSES*CNT_W-1:0] p_width,
  input  logic [NUM_PULSES*ATT_W-1:0] p_att,
  input  logic [ATT_W-1:0]            base_att,
  input  logic [CPMG_W-1:0]           cpmg_count,
  input  logic [CNT_W-1:0]            cpmg_delay,
  input  logic [CNT_W-1:0]            cpmg_width,
  input  logic                        block_en,
  input  logic [7:0]                  block_hold,
  input  logic [CNT_W-1:0]            rx_end,
  output logic                        sync_on,
  output logic                        pulse_on,
  output logic [ATT_W-1:0]            att,
  output logic                        inhib,
  output logic                        busy,
  output logic                        cycle_done
);

  // Echo compare values need two extra bits: last_end is CNT_W+1 wide and an
  // advanced pair may sit up to two steps beyond the counter range.
  localparam int EW = CNT_W + 2;
  localparam int SW = CNT_W + CPMG_W + 3;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  cfg_bank_t        pend, act, load_word;
  logic             load_pend;
  logic             run, wrap, transfer;

  assign run      = (state == RUN);
  assign wrap     = run && (cnt == act.period);
  assign transfer = load_pend && ((state == IDLE) || wrap);

  assign load_word = '{
    period:     period,
    sync_width: sync_width,
    p_en:       p_en,
    p_start:    p_start,
    p_width:    p_width,
    p_att:      p_att,
    base_att:   base_att,
    cpmg_count: cpmg_count,
    cpmg_delay: cpmg_delay,
    cpmg_width: cpmg_width,
    block_en:   block_en,
    block_hold: block_hold,
    rx_end:     rx_end
  };

  // NOTE: both banks are plain registers, so they are cleared by reset like any state.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      pend      <= '0;
      act       <= '0;
      load_pend <= 1'b0;
    end else begin
      if (transfer) act <= pend;
      if (load) begin
        pend      <= load_word;
        load_pend <= 1'b1;
      end else if (transfer) begin
        load_pend <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = trig_mode ? ARMED : RUN;
      end
      ARMED: begin
        if (!enable)   state_nxt = IDLE;
        else if (trig) state_nxt = RUN;
      end
      RUN: begin
        if (wrap) begin
          if (!enable)        state_nxt = IDLE;
          else if (trig_mode) state_nxt = ARMED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sequence geometry derived from the active bank.
  logic [CNT_W:0]     last_end, pend_end;
  logic [ATT_W-1:0]   echo_att;

  always_comb begin
    last_end = '0;
    pend_end = '0;
    echo_att = act.base_att;
    for (int i = 0; i < NUM_PULSES; i++) begin
      if (act.p_en[i]) begin
        pend_end = {1'b0, cnt_slice(act.p_start, i)} + {1'b0, cnt_slice(act.p_width, i)};
        if (pend_end > last_end) last_end = pend_end;
        echo_att = att_slice(act.p_att, i);
      end
    end
  end

  // Echo pair: reloaded at counter 0, stepped by delay+width at the end of each echo.
  logic [EW-1:0]     cs_q, ce_q, cur_cs, cur_ce, fresh_cs, fresh_ce, step, t_ext;
  logic [CPMG_W-1:0] idx_q, cur_idx;
  logic              echo_hit, advance;

  assign fresh_cs = EW'(last_end) + EW'(act.cpmg_delay);
  assign fresh_ce = fresh_cs + EW'(act.cpmg_width);
  assign step     = EW'(act.cpmg_delay) + EW'(act.cpmg_width);
  assign t_ext    = EW'(cnt);
  assign cur_cs   = (cnt == '0) ? fresh_cs : cs_q;
  assign cur_ce   = (cnt == '0) ? fresh_ce : ce_q;
  assign cur_idx  = (cnt == '0) ? '0 : idx_q;
  assign echo_hit = (act.cpmg_count != '0) && (t_ext >= cur_cs) && (t_ext < cur_ce);
  assign advance  = (t_ext == cur_ce - EW'(1))
                 && (({1'b0, cur_idx} + (CPMG_W+1)'(1)) < {1'b0, act.cpmg_count});

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      cs_q  <= '0;
      ce_q  <= '0;
      idx_q <= '0;
    end else if (run) begin
      if (advance) begin
        cs_q  <= cur_cs + step;
        ce_q  <= cur_ce + step;
        idx_q <= cur_idx + CPMG_W'(1);
      end else begin
        cs_q  <= cur_cs;
        ce_q  <= cur_ce;
        idx_q <= cur_idx;
      end
    end
  end

  // Blocking gate limit: end of the final echo (or last pulse) plus the hold.
  logic [SW-1:0] block_limit;
  logic          inhib_hit;

  assign block_limit = SW'(last_end)
                     + SW'(act.cpmg_count) * SW'(step)
                     + SW'(act.block_hold) * SW'(BLOCK_SCALE);
  assign inhib_hit   = act.block_en && ((SW'(cnt) < block_limit) || (cnt > act.rx_end));

  logic [NUM_PULSES-1:0] win_active;
  logic [ATT_W-1:0]      win_att [NUM_PULSES];

  for (genvar gi = 0; gi < NUM_PULSES; gi++) begin : g_win
    pulse_window #(
      .CNT_W (CNT_W),
      .ATT_W (ATT_W)
    ) u_win (
      .clk_pll (clk_pll),
      .reset   (reset),
      .run     (run),
      .en      (act.p_en[gi]),
      .t       (cnt),
      .start   (cnt_slice(act.p_start, gi)),
      .width   (cnt_slice(act.p_width, gi)),
      .att_in  (att_slice(act.p_att, gi)),
      .active  (win_active[gi]),
      .att     (win_att[gi])
    );
  end

  logic             echo_q;
  logic [ATT_W-1:0] echo_att_q, base_att_q;

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      sync_on    <= 1'b0;
      inhib      <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      echo_q     <= 1'b0;
      echo_att_q <= ATT_MAX;
      base_att_q <= ATT_MAX;
    end else begin
      sync_on    <= run && (cnt < act.sync_width);
      inhib      <= run && inhib_hit;
      busy       <= run;
      cycle_done <= wrap;
      echo_q     <= run && echo_hit;
      echo_att_q <= echo_att;
      base_att_q <= act.base_att;
    end
  end

  assign pulse_on = (|win_active) || echo_q;

  // Lowest-index active pulse wins, then an echo, then the base word.
  always_comb begin
    att = echo_q ? echo_att_q : base_att_q;
    for (int i = NUM_PULSES - 1; i >= 0; i--) begin
      if (win_active[i]) att = win_att[i];
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a behavioural model predicts every
// output cycle from the sequencing rules; a monitor pops and compares.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

  localparam int NP = 3;
  localparam int CW = 32;
  localparam int AW = 7;
  localparam int PW = 8;

  logic              clk_pll = 1'b0;
  logic              reset, enable, trig_mode, trig, load;
  logic [CW-1:0]     period, sync_width, cpmg_delay, cpmg_width, rx_end;
  logic [NP-1:0]     p_en;
  logic [NP*CW-1:0]  p_start, p_width;
  logic [NP*AW-1:0]  p_att;
  logic [AW-1:0]     base_att;
  logic [PW-1:0]     cpmg_count;
  logic              block_en;
  logic [7:0]        block_hold;
  logic              sync_on, pulse_on, inhib, busy, cycle_done;
  logic [AW-1:0]     att;

  pulse_sequencer dut (
    .clk_pll    (clk_pll),
    .reset      (reset),
    .enable     (enable),
    .trig_mode  (trig_mode),
    .trig       (trig),
    .load       (load),
    .period     (period),
    .sync_width (sync_width),
    .p_en       (p_en),
    .p_start    (p_start),
    .p_width    (p_width),
    .p_att      (p_att),
    .base_att   (base_att),
    .cpmg_count (cpmg_count),
    .cpmg_delay (cpmg_delay),
    .cpmg_width (cpmg_width),
    .block_en   (block_en),
    .block_hold (block_hold),
    .rx_end     (rx_end),
    .sync_on    (sync_on),
    .pulse_on   (pulse_on),
    .att        (att),
    .inhib      (inhib),
    .busy       (busy),
    .cycle_done (cycle_done)
  );

  always #5 clk_pll = ~clk_pll;

  typedef struct {
    longint period, sync_width, delay, ewidth, rx_end;
    bit     en [NP];
    longint start [NP];
    longint width [NP];
    int     patt [NP];
    int     base, count, hold;
    bit     blk;
  } cfg_t;

  typedef struct {
    bit    sync, pulse, inh, bsy, done;
    int    att;
    string tag;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  string  phase = "reset";

  // Model state: 0 idle, 1 armed, 2 running.
  int     m_mode;
  longint m_t;
  cfg_t   m_act, m_pend;
  bit     m_lp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic cfg_t zero_cfg();
    cfg_t c;
    c.period = 0; c.sync_width = 0; c.delay = 0; c.ewidth = 0; c.rx_end = 0;
    c.base = 0; c.count = 0; c.hold = 0; c.blk = 0;
    for (int i = 0; i < NP; i++) begin
      c.en[i] = 0; c.start[i] = 0; c.width[i] = 0; c.patt[i] = 0;
    end
    return c;
  endfunction

  function automatic cfg_t sample_cfg();
    cfg_t c;
    c.period = longint'(period);   c.sync_width = longint'(sync_width);
    c.delay  = longint'(cpmg_delay); c.ewidth   = longint'(cpmg_width);
    c.rx_end = longint'(rx_end);   c.base = int'(base_att);
    c.count  = int'(cpmg_count);   c.hold = int'(block_hold); c.blk = block_en;
    for (int i = 0; i < NP; i++) begin
      c.en[i]    = p_en[i];
      c.start[i] = longint'(p_start[i*CW +: CW]);
      c.width[i] = longint'(p_width[i*CW +: CW]);
      c.patt[i]  = int'(p_att[i*AW +: AW]);
    end
    return c;
  endfunction

  // Outputs expected for counter value t of a running period.
  function automatic exp_t expect_run(input cfg_t c, input longint t);
    exp_t   e;
    longint last_end = 0;
    longint s, seq_end;
    bit     echo = 0;
    int     hi_att = c.base;
    e.sync  = (t < c.sync_width);
    e.pulse = 0;
    e.att   = -1;
    for (int i = 0; i < NP; i++) begin
      if (c.en[i]) begin
        if (c.start[i] + c.width[i] > last_end) last_end = c.start[i] + c.width[i];
        hi_att = c.patt[i];
        if (t >= c.start[i] && t < c.start[i] + c.width[i]) begin
          e.pulse = 1;
          if (e.att < 0) e.att = c.patt[i];
        end
      end
    end
    for (int k = 0; k < c.count; k++) begin
      s = last_end + (k + 1) * c.delay + k * c.ewidth;
      if (t >= s && t < s + c.ewidth) echo = 1;
    end
    if (echo) e.pulse = 1;
    if (e.att < 0) e.att = echo ? hi_att : c.base;
    seq_end = last_end + c.count * (c.delay + c.ewidth);
    e.inh   = c.blk && ((t < seq_end + c.hold * 10) || (t > c.rx_end));
    e.bsy   = 1;
    e.done  = (t == c.period);
    return e;
  endfunction

  // One clock: predict the outputs produced by this edge, advance the model, clock.
  task automatic cyc();
    exp_t e;
    bit   tr;
    cfg_t nxt;
    if (!reset) begin
      e.sync = 0; e.pulse = 0; e.inh = 0; e.bsy = 0; e.done = 0; e.att = 127;
      m_mode = 0; m_t = 0; m_act = zero_cfg(); m_pend = zero_cfg(); m_lp = 0;
    end else begin
      if (m_mode == 2) e = expect_run(m_act, m_t);
      else begin
        e.sync = 0; e.pulse = 0; e.inh = 0; e.bsy = 0; e.done = 0; e.att = m_act.base;
      end
      tr  = m_lp && (m_mode == 0 || (m_mode == 2 && m_t == m_act.period));
      nxt = tr ? m_pend : m_act;
      if (load) begin
        m_pend = sample_cfg();
        m_lp   = 1;
      end else if (tr) m_lp = 0;
      case (m_mode)
        0: if (enable) begin m_mode = trig_mode ? 1 : 2; m_t = 0; end
        1: if (!enable) m_mode = 0; else if (trig) begin m_mode = 2; m_t = 0; end
        default: begin
          if (m_t == m_act.period) begin
            m_t = 0;
            if (!enable) m_mode = 0;
            else if (trig_mode) m_mode = 1;
          end else m_t++;
        end
      endcase
      m_act = nxt;
    end
    e.tag = phase;
    sb_q.push_back(e);
    @(posedge clk_pll);
    @(negedge clk_pll);
    trig = 1'b0;
    load = 1'b0;
  endtask

  always @(negedge clk_pll) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s@%0t {sync,pulse,inhib,busy,done,att}", e.tag, $time),
            {20'd0, sync_on, pulse_on, inhib, busy, cycle_done, att},
            {20'd0, e.sync, e.pulse, e.inh, e.bsy, e.done, 7'(e.att)});
    end
  end

  task automatic set_pulse(input int i, input bit en, input logic [31:0] st,
                           input logic [31:0] wd, input logic [6:0] a);
    p_en[i]           = en;
    p_start[i*CW +: CW] = st;
    p_width[i*CW +: CW] = wd;
    p_att[i*AW +: AW]   = a;
  endtask

  task automatic clear_cfg();
    period = 32'd99; sync_width = '0; cpmg_delay = '0; cpmg_width = '0; rx_end = '0;
    p_en = '0; p_start = '0; p_width = '0; p_att = '0; base_att = '0;
    cpmg_count = '0; block_en = 1'b0; block_hold = '0;
  endtask

  task automatic load_cfg();
    load = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic run_until(input longint target, input int budget);
    int n = 0;
    while (!(m_mode == 2 && m_t == target) && n < budget) begin
      cyc();
      n++;
    end
    check($sformatf("%s reach t=%0d", phase, target), 32'(n < budget), 32'd1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; trig_mode = 1'b0; trig = 1'b0; load = 1'b0;
    clear_cfg();
    repeat (3) cyc();
    reset = 1'b1;
    repeat (2) cyc();

    phase = "freerun";
    sync_width = 32'd10;
    set_pulse(0, 1, 0, 5, 4);
    set_pulse(1, 1, 20, 10, 6);
    base_att = 7'd3;
    load_cfg();
    enable = 1'b1;
    run_until(40, 200);
    phase = "load_mid";
    p_width[1*CW +: CW] = 32'd3;
    load = 1'b1;
    repeat (220) cyc();
    enable = 1'b0;
    repeat (110) cyc();

    phase = "cpmg";
    clear_cfg();
    sync_width = 32'd5;
    set_pulse(0, 1, 0, 30, 10);
    cpmg_count = 8'd3; cpmg_delay = 32'd10; cpmg_width = 32'd4;
    block_en = 1'b1; block_hold = 8'd2; rx_end = 32'd95; base_att = 7'd1;
    load_cfg();
    enable = 1'b1;
    repeat (120) cyc();
    enable = 1'b0;
    repeat (110) cyc();

    phase = "trig";
    clear_cfg();
    set_pulse(0, 1, 5, 10, 8);
    base_att = 7'd2;
    load_cfg();
    trig_mode = 1'b1; enable = 1'b1;
    repeat (3) cyc();
    trig = 1'b1;
    cyc();
    repeat (49) cyc();
    trig = 1'b1;
    cyc();
    repeat (80) cyc();
    enable = 1'b0; trig_mode = 1'b0;
    repeat (3) cyc();

    phase = "overlap";
    clear_cfg();
    period = 32'd49;
    set_pulse(0, 1, 0, 20, 5);
    set_pulse(1, 1, 10, 20, 9);
    base_att = 7'd3;
    load_cfg();
    enable = 1'b1;
    repeat (60) cyc();
    enable = 1'b0;
    repeat (60) cyc();

    for (int r = 0; r < 6; r++) begin
      phase = $sformatf("rand%0d", r);
      period     = 32'($urandom_range(120, 20));
      sync_width = 32'($urandom_range(125, 0));
      for (int i = 0; i < NP; i++)
        set_pulse(i, 1'($urandom_range(1, 0)), 32'($urandom_range(130, 0)),
                  ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(30, 0)),
                  7'($urandom_range(127, 0)));
      base_att   = 7'($urandom_range(127, 0));
      cpmg_count = 8'($urandom_range(4, 0));
      cpmg_delay = 32'($urandom_range(15, 0));
      cpmg_width = 32'($urandom_range(8, 0));
      block_en   = 1'($urandom_range(1, 0));
      block_hold = 8'($urandom_range(6, 0));
      rx_end     = 32'($urandom_range(125, 0));
      load_cfg();
      trig_mode = 1'($urandom_range(1, 0));
      enable    = 1'b1;
      for (int c = 0; c < 350; c++) begin
        trig = ($urandom_range(40, 0) == 0);
        if ($urandom_range(150, 0) == 0) begin
          p_width[0 +: CW] = 32'($urandom_range(30, 0));
          load = 1'b1;
        end
        if (c == 300) enable = 1'b0;
        cyc();
      end
      repeat (130) cyc();
    end

    phase = "reset_mid";
    trig_mode = 1'b0;
    clear_cfg();
    set_pulse(0, 1, 50, 20, 12);
    sync_width = 32'd70;
    base_att = 7'd2;
    load_cfg();
    enable = 1'b1;
    run_until(57, 200);
    reset = 1'b0;
    enable = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (5) cyc();

    repeat (2) @(negedge clk_pll);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
